// File: rtl/reset_sequencer.sv
// reset_sequencer: PLL-lock / button reset sequencer with peripheral-then-core release.
// Define RESET_SEQ_SWRST_EN to let sw_reset_req abort RUN (cause 3).
module reset_sequencer #(
  parameter int STRETCH_CYCLES  = 4194303,
  parameter int GAP_CYCLES      = 1024,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit BUTTON_LOW      = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       lock,
  input  logic       button,
  input  logic       sw_reset_req,
  output logic       reset_periph,
  output logic       reset_core,
  output logic       ready,
  output logic [1:0] last_cause,
  output logic [7:0] lock_lost_count
);

  // state   | meaning
  // HOLD    | both resets held, waiting for lock and released button
  // STRETCH | both resets held for STRETCH_CYCLES
  // PERIPH  | peripherals released, core held for GAP_CYCLES
  // RUN     | everything released
  localparam logic [1:0] S_HOLD    = 2'd0;
  localparam logic [1:0] S_STRETCH = 2'd1;
  localparam logic [1:0] S_PERIPH  = 2'd2;
  localparam logic [1:0] S_RUN     = 2'd3;

  localparam int CNT_MAX = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] STRETCH_LOAD = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD     = CW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_CYCLES - 1);

  logic          lock_m, lock_s;
  logic          btn_raw, btn_m, btn_s;
  logic          btn_db;
  logic [DW-1:0] db_cnt;
  logic          good, sw_abort, abort;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    cause_nxt;
  logic [7:0]    lost_nxt;

  assign btn_raw = BUTTON_LOW ? ~button : button;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
      btn_m  <= btn_raw;
      btn_s  <= btn_m;
    end
  end

  // Any sample agreeing with the debounced level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= btn_s;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  assign good = lock_s & ~btn_db;

`ifdef RESET_SEQ_SWRST_EN
  assign sw_abort = sw_reset_req & (state == S_RUN);
`else
  logic unused_sw_reset_req;
  assign unused_sw_reset_req = sw_reset_req;
  assign sw_abort = 1'b0;
`endif

  assign abort = (state != S_HOLD) & (~lock_s | btn_db | sw_abort);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = last_cause;
    lost_nxt  = lock_lost_count;
    if (abort) begin
      state_nxt = S_HOLD;
      cnt_nxt   = '0;
      if (!lock_s) begin
        cause_nxt = 2'd1;
        if (lock_lost_count != 8'hFF) lost_nxt = lock_lost_count + 8'd1;
      end else if (btn_db) begin
        cause_nxt = 2'd2;
      end
`ifdef RESET_SEQ_SWRST_EN
      else begin
        cause_nxt = 2'd3;
      end
`endif
    end else begin
      case (state)
        S_HOLD: begin
          if (good) begin
            state_nxt = S_STRETCH;
            cnt_nxt   = STRETCH_LOAD;
          end
        end
        S_STRETCH: begin
          if (cnt == '0) begin
            state_nxt = S_PERIPH;
            cnt_nxt   = GAP_LOAD;
          end else begin
            cnt_nxt = cnt - CW'(1);
          end
        end
        S_PERIPH: begin
          if (cnt == '0) state_nxt = S_RUN;
          else cnt_nxt = cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they change with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_HOLD;
      cnt             <= '0;
      reset_periph    <= 1'b1;
      reset_core      <= 1'b1;
      ready           <= 1'b0;
      last_cause      <= 2'd0;
      lock_lost_count <= 8'd0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      reset_periph    <= (state_nxt == S_HOLD) | (state_nxt == S_STRETCH);
      reset_core      <= (state_nxt != S_RUN);
      ready           <= (state_nxt == S_RUN);
      last_cause      <= cause_nxt;
      lock_lost_count <= lost_nxt;
    end
  end

endmodule
